// File: rtl/nn_pkg.sv
// Shared definitions for the neuron MAC: FSM states and default parameter values.
package nn_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_N_IN    = 8;
    localparam int DEF_ACC_W   = 24;
    localparam int DEF_OUT_W   = 16;
    localparam int DEF_FRAC_SH = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_POST = 2'd2,
        ST_OUT  = 2'd3
    } nn_state_e;

    // Width of a counter that must hold 0..n-1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nn_neuron_mac_if.sv
// Handshake bundle for nn_neuron_mac: start/bias, x/w input stream, y output stream.
interface nn_neuron_mac_if
    import nn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OUT_W  = DEF_OUT_W
);
    logic                     start;
    logic signed [ACC_W-1:0]  bias;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] w;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  y;
    logic                     busy;

    modport master (
        output start, bias, in_valid, x, w, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  start, bias, in_valid, x, w, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface

// File: rtl/nn_act_sat.sv
// Post-accumulation path: arithmetic shift, optional ReLU (NN_NEURON_RELU_EN), saturation.
module nn_act_sat #(
    parameter int ACC_W   = 24,
    parameter int OUT_W   = 16,
    parameter int FRAC_SH = 0
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [OUT_W-1:0] o_y
);
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0] w_sh;
    logic signed [ACC_W-1:0] w_act;

    assign w_sh = i_acc >>> FRAC_SH;

`ifdef NN_NEURON_RELU_EN
    assign w_act = w_sh[ACC_W-1] ? '0 : w_sh;
`else
    assign w_act = w_sh;
`endif

    always_comb begin
        o_y = w_act[OUT_W-1:0];
        if (w_act > MAX_V)
            o_y = MAX_V[OUT_W-1:0];
        else if (w_act < MIN_V)
            o_y = MIN_V[OUT_W-1:0];
    end

endmodule

// File: rtl/nn_neuron_mac.sv
// Single neuron: y = sat(act((bias + sum x*w) >>> FRAC_SH)) over N_IN pairs.
// Define NN_NEURON_RELU_EN for a ReLU activation; default build is linear.
module nn_neuron_mac
    import nn_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int N_IN    = DEF_N_IN,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int FRAC_SH = DEF_FRAC_SH
) (
    input  logic            clk,
    input  logic            rst,
    nn_neuron_mac_if.slave  nif
);
    localparam int CNT_W = cnt_w(N_IN);

    nn_state_e               r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_count;
    logic signed [OUT_W-1:0] r_y;
    logic                    r_out_valid;
    logic                    r_in_ready;
    logic                    r_busy;

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [OUT_W-1:0]    w_y;
    logic                       w_xfer;

    // Full-width product, sign-extended so the accumulator wraps modulo 2^ACC_W.
    assign w_prod     = nif.x * nif.w;
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_xfer     = nif.in_valid && r_in_ready;

    nn_act_sat #(
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W),
        .FRAC_SH (FRAC_SH)
    ) u_act_sat (
        .i_acc (r_acc),
        .o_y   (w_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (nif.start) begin
                        r_acc      <= nif.bias;
                        r_count    <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (w_xfer) begin
                        r_acc   <= r_acc + w_prod_ext;
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == CNT_W'(N_IN-1)) begin
                            r_in_ready <= 1'b0;
                            r_state    <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    r_y         <= w_y;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    // y holds until the consumer takes it; one IDLE cycle follows.
                    if (nif.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign nif.in_ready  = r_in_ready;
    assign nif.out_valid = r_out_valid;
    assign nif.y         = r_y;
    assign nif.busy      = r_busy;

endmodule

// File: tb/tb_nn_neuron_mac.sv
// Randomized bench for nn_neuron_mac against a queue-based neuron model; two DUTs (FRAC_SH 0 and 2).
module tb_nn_neuron_mac;
    localparam int DW = 8;
    localparam int NI = 4;
    localparam int AW = 24;
    localparam int OW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nn_neuron_mac_if #(.DATA_W(DW), .ACC_W(AW), .OUT_W(OW)) if0 ();
    nn_neuron_mac_if #(.DATA_W(DW), .ACC_W(AW), .OUT_W(OW)) if1 ();

    assign if1.start     = if0.start;
    assign if1.bias      = if0.bias;
    assign if1.in_valid  = if0.in_valid;
    assign if1.x         = if0.x;
    assign if1.w         = if0.w;
    assign if1.out_ready = if0.out_ready;

    nn_neuron_mac #(.DATA_W(DW), .N_IN(NI), .ACC_W(AW), .OUT_W(OW), .FRAC_SH(0))
        dut0 (.clk(clk), .rst(rst), .nif(if0));
    nn_neuron_mac #(.DATA_W(DW), .N_IN(NI), .ACC_W(AW), .OUT_W(OW), .FRAC_SH(2))
        dut1 (.clk(clk), .rst(rst), .nif(if1));

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tmo(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out waiting on DUT (cycle %0d)", nm, cyc);
    endtask

    // Model: the neuron as a list of products, evaluated with plain integer math.
    bit     armed = 0, prev_rst = 0, m_active = 0, have_exp = 0;
    int     due;
    longint m_bias, exp_y0, exp_y1;
    longint q[$];
    logic signed [OW-1:0] last_y0, last_y1;

    function automatic longint ref_y(input longint b, input int sh);
        longint s = b;
        foreach (q[i]) s += q[i];
        s = s & 64'hFF_FFFF;
        if (s[23]) s -= 64'h100_0000;
        s = s >>> sh;
`ifdef NN_NEURON_RELU_EN
        if (s < 0) s = 0;
`endif
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    always @(negedge clk) begin
        bit act;
        cyc++;
        act = m_active;
        if (armed) begin
            if (prev_rst) begin
                chk("rst_y0", if0.y, 0);
                chk("rst_y1", if1.y, 0);
            end
            chk("busy", if0.busy, m_active);
            chk("in_ready", if0.in_ready, (m_active && q.size() < NI));
            chk("out_valid0", if0.out_valid, (have_exp && cyc >= due));
            chk("out_valid1", if1.out_valid, (have_exp && cyc >= due));
            if (have_exp && cyc >= due) begin
                chk("y0", if0.y, exp_y0);
                chk("y1", if1.y, exp_y1);
            end
        end
        if (rst) begin
            armed = 1; prev_rst = 1; m_active = 0; have_exp = 0;
            q.delete();
        end else if (armed) begin
            prev_rst = 0;
            if (have_exp && cyc >= due && if0.out_ready) begin
                last_y0 = if0.y; last_y1 = if1.y;
                m_active = 0; have_exp = 0;
            end
            if (act && if0.in_valid && q.size() < NI) begin
                q.push_back(longint'(if0.x) * longint'(if0.w));
                if (q.size() == NI) begin
                    exp_y0 = ref_y(m_bias, 0);
                    exp_y1 = ref_y(m_bias, 2);
                    have_exp = 1;
                    due = cyc + 2;
                end
            end
            if (!act && if0.start) begin
                m_active = 1; m_bias = longint'(if0.bias);
                q.delete();
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic begin_neuron(input logic signed [AW-1:0] b);
        int t = 0;
        while (if0.busy && t < 200) begin step(); t++; end
        if (t >= 200) tmo("start_wait");
        if0.start = 1'b1; if0.bias = b;
        step();
        if0.start = 1'b0;
    endtask

    task automatic send(input logic signed [DW-1:0] xv, input logic signed [DW-1:0] wv);
        int t = 0;
        if0.in_valid = 1'b1; if0.x = xv; if0.w = wv;
        while (!if0.in_ready && t < 200) begin step(); t++; end
        if (t >= 200) tmo("in_ready_wait");
        step();
    endtask

    task automatic finish_neuron(input int stall, input bit poke_start);
        int t = 0;
        if0.in_valid = 1'b0; if0.out_ready = 1'b0;
        while (!if0.out_valid && t < 200) begin step(); t++; end
        if (t >= 200) tmo("out_valid_wait");
        for (int i = 0; i < stall; i++) begin
            if0.start = poke_start; if0.bias = 24'sd777;
            step();
        end
        if0.start = 1'b0;
        if0.out_ready = 1'b1;
        step();
    endtask

    initial begin
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int k;
        rst = 1'b1;
        if0.start = 0; if0.bias = '0; if0.in_valid = 0; if0.x = '0; if0.w = '0; if0.out_ready = 0;
        step(); step();
        rst = 1'b0;
        chk("reset_busy", if0.busy, 0);
        chk("reset_out_valid", if0.out_valid, 0);

        // Sum of 1..4, back to back.
        begin_neuron(0);
        for (int i = 1; i <= 4; i++) send(DW'(i), 8'sd1);
        finish_neuron(0, 0);
        chk("d_sum10", last_y0, 10);

        // Single negative product.
        begin_neuron(0);
        send(-8'sd5, 8'sd3);
        for (int i = 0; i < 3; i++) send(8'sd0, 8'sd0);
        finish_neuron(0, 0);
`ifdef NN_NEURON_RELU_EN
        chk("d_relu", last_y0, 0);
`else
        chk("d_linear", last_y0, -15);
`endif

        // Saturation and shifted result.
        begin_neuron(0);
        for (int i = 0; i < 4; i++) send(8'sd127, 8'sd127);
        finish_neuron(0, 0);
        chk("d_sat", last_y0, 32767);
        chk("d_shift2", last_y1, 16129);

        // Valid gaps, stalled consumer, start pulses while busy.
        begin_neuron(0);
        k = 1;
        for (int i = 0; i < 7; i++) begin
            if0.in_valid = pat[i][0];
            if (pat[i] == 1) begin if0.x = DW'(k); if0.w = 8'sd1; k++; end
            if0.start = (i == 2); if0.bias = 24'sd999;
            step();
        end
        if0.start = 1'b0;
        finish_neuron(5, 1);
        chk("d_gaps", last_y0, 10);

        // Reset after the second transfer, then a fresh neuron.
        begin_neuron(0);
        send(8'sd9, 8'sd9); send(8'sd9, 8'sd9);
        if0.in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("d_rst_busy", if0.busy, 0);
        chk("d_rst_in_ready", if0.in_ready, 0);
        chk("d_rst_out_valid", if0.out_valid, 0);
        chk("d_rst_y", if0.y, 0);
        begin_neuron(100);
        send(8'sd3, 8'sd4); send(-8'sd2, 8'sd5); send(8'sd7, -8'sd1); send(8'sd1, 8'sd10);
        finish_neuron(0, 0);
        chk("d_after_rst", last_y0, 105);

        // Random neurons.
        for (int n = 0; n < 30; n++) begin
            logic signed [AW-1:0] b;
            int rst_at;
            b = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($signed($urandom_range(0, 2000)) - 1000);
            rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, NI - 1) : -1;
            begin_neuron(b);
            for (int i = 0; i < NI; i++) begin
                if (i == rst_at) begin
                    if0.in_valid = 1'b0; rst = 1'b1;
                    step();
                    rst = 1'b0;
                    break;
                end
                if ($urandom_range(0, 2) == 0) begin
                    if0.in_valid = 1'b0;
                    if0.start = $urandom_range(0, 1) == 1;
                    repeat ($urandom_range(1, 2)) step();
                    if0.start = 1'b0;
                end
                send(DW'($urandom), DW'($urandom));
            end
            if (rst_at < 0) finish_neuron($urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end

        step(); step();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_err);
        $fatal(1);
    end

endmodule
